// File: rtl/apb_pvci_pkg.sv
// Shared types and helpers for the APB-to-PVCI multi-channel bridge.
// The optional acknowledge timeout is enabled with APB_PVCI_TIMEOUT_EN.
package apb_pvci_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    // Channel index width; a single channel still gets one index bit.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 2) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/apb_pvci_decode.sv
// Combinational APB address decoder: paddr -> {channel, register index, decode error}.
// Part of apb_pvci_bridge_mc (optional timeout macro APB_PVCI_TIMEOUT_EN has no effect here).
module apb_pvci_decode
    import apb_pvci_pkg::*;
#(
    parameter int          NUM_CH         = 2,
    parameter int          PVCI_AW        = 8,
    parameter logic [31:0] BASE_ADDRESS   = 32'h1A10_8000,
    parameter int          CH_STRIDE_LOG2 = 12,
    parameter int          CH_W           = ch_width(NUM_CH)
) (
    input  logic [31:0]        paddr,
    output logic [CH_W-1:0]    ch,
    output logic [PVCI_AW-1:0] reg_idx,
    output logic               err
);

    localparam logic [32:0] WINDOW   = 33'(NUM_CH) << CH_STRIDE_LOG2;
    // Offset bits above the register field but below the channel field must be zero.
    localparam logic [31:0] GAP_MASK = ((32'd1 << CH_STRIDE_LOG2) - 32'd1)
                                     & ~((32'd1 << (PVCI_AW + 2)) - 32'd1);

    logic [31:0] off;

    always_comb begin
        off     = paddr - BASE_ADDRESS;
        err     = (paddr < BASE_ADDRESS)
               || ({1'b0, off} >= WINDOW)
               || (off[1:0] != 2'b00)
               || ((off & GAP_MASK) != 32'd0);
        ch      = off[CH_STRIDE_LOG2 +: CH_W];
        reg_idx = off[2 +: PVCI_AW];
    end

endmodule

// File: rtl/apb_pvci_bridge_mc.sv
// APB slave bridging word accesses onto NUM_CH PVCI register ports with wait states.
// Define APB_PVCI_TIMEOUT_EN to abort unacknowledged requests after TIMEOUT cycles.
module apb_pvci_bridge_mc
    import apb_pvci_pkg::*;
#(
    parameter int          NUM_CH         = 2,
    parameter int          PVCI_AW        = 8,
    parameter int          PVCI_DW        = 8,
    parameter logic [31:0] BASE_ADDRESS   = 32'h1A10_8000,
    parameter int          CH_STRIDE_LOG2 = 12,
    parameter int          TIMEOUT        = 63
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic [31:0]               paddr,
    input  logic                      pwrite,
    input  logic [31:0]               pwdata,
    input  logic                      psel,
    input  logic                      penable,
    output logic [31:0]               prdata,
    output logic                      pready,
    output logic                      pslverr,
    output logic [NUM_CH-1:0]         pvci_valid,
    output logic                      pvci_rd,
    output logic [PVCI_AW-1:0]        pvci_addr,
    output logic [PVCI_DW-1:0]        pvci_wd,
    input  logic [NUM_CH-1:0]         pvci_ack,
    input  logic [NUM_CH*PVCI_DW-1:0] pvci_rdata
);

    localparam int CH_W = ch_width(NUM_CH);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [PVCI_AW-1:0]  addr_q, addr_d;
    logic                rd_q, rd_d;
    logic [PVCI_DW-1:0]  wd_q, wd_d;
    logic [31:0]         prdata_q, prdata_d;

    logic [CH_W-1:0]     dec_ch;
    logic [PVCI_AW-1:0]  dec_reg;
    logic                dec_err;
    logic                setup;
    logic [NUM_CH-1:0]   ch_oh;
    logic                ack_sel;
    logic [PVCI_DW-1:0]  rdata_sel;
    logic                expire;

    apb_pvci_decode #(
        .NUM_CH         (NUM_CH),
        .PVCI_AW        (PVCI_AW),
        .BASE_ADDRESS   (BASE_ADDRESS),
        .CH_STRIDE_LOG2 (CH_STRIDE_LOG2),
        .CH_W           (CH_W)
    ) u_decode (
        .paddr   (paddr),
        .ch      (dec_ch),
        .reg_idx (dec_reg),
        .err     (dec_err)
    );

    assign setup = psel & ~penable;

    // Only the latched channel's ack and read data are ever looked at.
    always_comb begin
        ch_oh     = '0;
        rdata_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_oh[c]  = (ch_q == CH_W'(c));
            rdata_sel = rdata_sel | (pvci_rdata[c*PVCI_DW +: PVCI_DW] & {PVCI_DW{ch_oh[c]}});
        end
        ack_sel = |(pvci_ack & ch_oh);
    end

`ifdef APB_PVCI_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q != REQ)
            cnt_d = '0;
        else if (!ack_sel)
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Ack in the expiry cycle still wins; see the REQ branch of the next-state logic.
    assign expire = (state_q == REQ) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge pclk) begin
        if (preset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    logic [CNT_W-1:0] unused_timeout;
    assign unused_timeout = CNT_W'(TIMEOUT);
    assign expire         = 1'b0;
`endif

    logic unused_pwdata;
    assign unused_pwdata = ^pwdata;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (setup) state_d = dec_err ? ERR : REQ;
            REQ: begin
                if (ack_sel)     state_d = DONE;
                else if (expire) state_d = ERR;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ch_d     = ch_q;
        addr_d   = addr_q;
        rd_d     = rd_q;
        wd_d     = wd_q;
        prdata_d = prdata_q;
        if (state_q == IDLE && setup) begin
            ch_d   = dec_ch;
            addr_d = dec_reg;
            rd_d   = ~pwrite;
            wd_d   = pwdata[PVCI_DW-1:0];
            if (dec_err) prdata_d = '0;
        end else if (state_q == REQ) begin
            if (ack_sel && rd_q) prdata_d = 32'(rdata_sel);
            else if (!ack_sel && expire) prdata_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            wd_q     <= '0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            wd_q     <= wd_d;
            prdata_q <= prdata_d;
        end
    end

    // Outputs come from state and registers only; no APB input reaches them directly.
    always_comb begin
        pvci_valid = (state_q == REQ) ? ch_oh : '0;
        pvci_rd    = rd_q;
        pvci_addr  = addr_q;
        pvci_wd    = wd_q;
        prdata     = prdata_q;
        pready     = (state_q == DONE) || (state_q == ERR);
        pslverr    = (state_q == ERR);
    end

endmodule

// File: tb/tb_apb_pvci_bridge_mc.sv
// Scoreboard bench for apb_pvci_bridge_mc; covers the APB_PVCI_TIMEOUT_EN build when defined.
module tb_apb_pvci_bridge_mc;

    localparam int          NUM_CH = 2;
    localparam int          AW     = 8;
    localparam int          DW     = 8;
    localparam logic [31:0] BASE   = 32'h1A10_8000;
    localparam int          STRIDE = 12;
    localparam int          TO     = 4;
`ifdef APB_PVCI_TIMEOUT_EN
    localparam bit          TO_EN  = 1'b1;
`else
    localparam bit          TO_EN  = 1'b0;
`endif

    logic                 pclk;
    logic                 preset;
    logic [31:0]          paddr;
    logic                 pwrite;
    logic [31:0]          pwdata;
    logic                 psel;
    logic                 penable;
    logic [31:0]          prdata;
    logic                 pready;
    logic                 pslverr;
    logic [NUM_CH-1:0]    pvci_valid;
    logic                 pvci_rd;
    logic [AW-1:0]        pvci_addr;
    logic [DW-1:0]        pvci_wd;
    logic [NUM_CH-1:0]    pvci_ack;
    logic [NUM_CH*DW-1:0] pvci_rdata;

    apb_pvci_bridge_mc #(
        .NUM_CH         (NUM_CH),
        .PVCI_AW        (AW),
        .PVCI_DW        (DW),
        .BASE_ADDRESS   (BASE),
        .CH_STRIDE_LOG2 (STRIDE),
        .TIMEOUT        (TO)
    ) dut (
        .pclk       (pclk),
        .preset     (preset),
        .paddr      (paddr),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .psel       (psel),
        .penable    (penable),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .pvci_valid (pvci_valid),
        .pvci_rd    (pvci_rd),
        .pvci_addr  (pvci_addr),
        .pvci_wd    (pvci_wd),
        .pvci_ack   (pvci_ack),
        .pvci_rdata (pvci_rdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [NUM_CH-1:0] valid;
        logic              rd;
        logic [AW-1:0]     addr;
        logic [DW-1:0]     wd;
    } req_t;

    typedef struct {
        logic        err;
        logic [31:0] prdata;
        int          waits;
        int          vcycles;
    } rsp_t;

    req_t        req_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] model_prdata = 32'h0;

    // Reference decode from plain address arithmetic.
    function automatic void model_decode(input logic [31:0] a, output bit err,
                                         output int ch, output int rg);
        longint off;
        err = 1'b0;
        ch  = 0;
        rg  = 0;
        if (a < BASE) begin
            err = 1'b1;
        end else begin
            off = longint'(a) - longint'(BASE);
            ch  = int'(off / (64'd1 << STRIDE));
            rg  = int'((off % (64'd1 << STRIDE)) / 4);
            if (ch >= NUM_CH || (off % 4) != 0 || rg >= (1 << AW)) err = 1'b1;
        end
    endfunction

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle();
        step();
        psel     = 1'b0;
        penable  = 1'b0;
        pvci_ack = NUM_CH'($urandom);
    endtask

    // One APB transfer; the selected channel acks in its d-th REQ cycle (0 = first).
    task automatic xfer(input logic [31:0] a, input bit wr, input logic [31:0] wdata,
                        input int d, input logic [DW-1:0] rdv, input bit drop_psel);
        bit   err;
        bit   timed_out;
        int   ch;
        int   rg;
        int   k;
        req_t rq;
        rsp_t rs;
        model_decode(a, err, ch, rg);
        step();
        psel     = 1'b1;
        penable  = 1'b0;
        paddr    = a;
        pwrite   = wr;
        pwdata   = wdata;
        pvci_ack = NUM_CH'($urandom);
        if (err) begin
            model_prdata = 32'h0;
            rs = '{err: 1'b1, prdata: 32'h0, waits: 0, vcycles: 0};
        end else begin
            rq = '{valid: NUM_CH'(1) << ch, rd: !wr, addr: AW'(rg), wd: wdata[DW-1:0]};
            req_q.push_back(rq);
            timed_out = TO_EN && (d >= TO);
            if (timed_out) begin
                model_prdata = 32'h0;
                rs = '{err: 1'b1, prdata: 32'h0, waits: TO, vcycles: TO};
            end else begin
                if (!wr) model_prdata = 32'(rdv);
                rs = '{err: 1'b0, prdata: model_prdata, waits: d + 1, vcycles: d + 1};
            end
        end
        rsp_q.push_back(rs);
        step();
        penable = 1'b1;
        k = 0;
        while (!pready && k < 300) begin
            pvci_ack   = NUM_CH'($urandom);
            pvci_rdata = (NUM_CH*DW)'($urandom);
            if (!err) begin
                pvci_ack[ch] = (k == d);
                if (k == d) pvci_rdata[ch*DW +: DW] = rdv;
            end
            if (drop_psel && k == 1) psel = 1'b0;
            step();
            k++;
        end
        if (!pready) check("xfer_bound", 32'(pready), 32'h1);
        pvci_ack = '0;
    endtask

    // Monitor: PVCI request checks and APB completion checks against the queues.
    bit                 in_xfer = 1'b0;
    int                 wcnt = 0;
    int                 vcnt = 0;
    logic [NUM_CH-1:0]  prev_valid = '0;
    logic [31:0]        prev_bus = '0;

    always @(negedge pclk) begin
        req_t rq;
        rsp_t rs;
        if (preset) begin
            in_xfer    = 1'b0;
            prev_valid = '0;
        end else begin
            if (pvci_valid != '0) begin
                check("valid_onehot", 32'($countones(pvci_valid)), 32'd1);
                check("valid_in_xfer", 32'(in_xfer), 32'd1);
                if (prev_valid == '0) begin
                    if (req_q.size() == 0) begin
                        check("req_expected", 32'(req_q.size()), 32'd1);
                    end else begin
                        rq = req_q.pop_front();
                        check("req_valid", 32'(pvci_valid), 32'(rq.valid));
                        check("req_rd",    32'(pvci_rd),    32'(rq.rd));
                        check("req_addr",  32'(pvci_addr),  32'(rq.addr));
                        check("req_wd",    32'(pvci_wd),    32'(rq.wd));
                    end
                end else begin
                    check("req_stable", 32'({pvci_valid, pvci_rd, pvci_addr, pvci_wd}), prev_bus);
                end
            end
            if (psel && !penable) begin
                check("setup_not_ready", 32'(pready), 32'd0);
                in_xfer = 1'b1;
                wcnt    = 0;
                vcnt    = 0;
            end else if (in_xfer) begin
                if (pvci_valid != '0) vcnt++;
                if (!pready) begin
                    wcnt++;
                end else if (rsp_q.size() == 0) begin
                    check("rsp_expected", 32'(rsp_q.size()), 32'd1);
                    in_xfer = 1'b0;
                end else begin
                    rs = rsp_q.pop_front();
                    check("rsp_pslverr", 32'(pslverr), 32'(rs.err));
                    check("rsp_prdata",  prdata,       rs.prdata);
                    check("rsp_waits",   32'(wcnt),    32'(rs.waits));
                    check("rsp_vcycles", 32'(vcnt),    32'(rs.vcycles));
                    in_xfer = 1'b0;
                end
            end else if (pready) begin
                check("pready_spurious", 32'(pready), 32'd0);
            end
            prev_valid = pvci_valid;
            prev_bus   = 32'({pvci_valid, pvci_rd, pvci_addr, pvci_wd});
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},   32'(pvci_valid), 32'd0);
        check({tag, "_pready"},  32'(pready),     32'd0);
        check({tag, "_pslverr"}, 32'(pslverr),    32'd0);
        check({tag, "_prdata"},  prdata,          32'd0);
        check({tag, "_rd"},      32'(pvci_rd),    32'd0);
        check({tag, "_addr"},    32'(pvci_addr),  32'd0);
        check({tag, "_wd"},      32'(pvci_wd),    32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ch;
        int          rg;
        int          kind;
        logic [31:0] a;
        preset     = 1'b1;
        psel       = 1'b0;
        penable    = 1'b0;
        paddr      = '0;
        pwrite     = 1'b0;
        pwdata     = '0;
        pvci_ack   = '0;
        pvci_rdata = '0;
        repeat (3) step();
        check_reset_outputs("reset");
        preset = 1'b0;

        // Directed transfers.
        xfer(BASE + 32'h100C, 1'b0, 32'h0,        2, 8'hA5, 1'b0);
        xfer(BASE,            1'b1, 32'hDEADBE5A, 0, 8'h00, 1'b0);
        xfer(BASE + 32'h2000, 1'b0, 32'h0,        0, 8'h11, 1'b0);
        xfer(BASE + 32'h0002, 1'b1, 32'h12345678, 0, 8'h22, 1'b0);
        xfer(BASE - 32'h4,    1'b0, 32'h0,        0, 8'h33, 1'b0);
        xfer(BASE + 32'h0400, 1'b0, 32'h0,        0, 8'h44, 1'b0);
        xfer(BASE + 32'h13FC, 1'b0, 32'h0,        1, 8'h5C, 1'b0);
        xfer(BASE + 32'h0008, 1'b0, 32'h0,        9, 8'h66, 1'b0);
        xfer(BASE + 32'h1010, 1'b0, 32'h0,        3, 8'h77, 1'b0);
        xfer(BASE + 32'h0014, 1'b1, 32'h000000C3, 3, 8'h88, 1'b1);
        idle();

        // Back-to-back read ch0 then write ch1, immediate acks.
        xfer(BASE + 32'h0020, 1'b0, 32'h0,        0, 8'h9E, 1'b0);
        xfer(BASE + 32'h1024, 1'b1, 32'h000000B7, 0, 8'h00, 1'b0);

        // Reset in the second REQ cycle abandons the transfer.
        step();
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = BASE + 32'h1014;
        pwrite  = 1'b1;
        pwdata  = 32'h0000_00E1;
        req_q.push_back('{valid: 2'b10, rd: 1'b0, addr: 8'd5, wd: 8'hE1});
        step();
        penable  = 1'b1;
        pvci_ack = '0;
        step();
        preset = 1'b1;
        step();
        check_reset_outputs("midreset");
        preset       = 1'b0;
        psel         = 1'b0;
        penable      = 1'b0;
        model_prdata = 32'h0;
        xfer(BASE + 32'h1018, 1'b0, 32'h0, 1, 8'h3C, 1'b0);

        // Randomized traffic, mostly legal addresses with some decode faults.
        for (int i = 0; i < 40; i++) begin
            ch   = $urandom_range(0, NUM_CH);
            rg   = $urandom_range(0, (1 << AW) - 1);
            kind = $urandom_range(0, 9);
            a    = BASE + (32'(ch) << STRIDE) + (32'(rg) << 2);
            if (kind == 0) a = a + 32'($urandom_range(1, 3));
            if (kind == 1) a = a | 32'h0000_0800;
            xfer(a, 1'($urandom), $urandom, $urandom_range(0, 6), DW'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) idle();
        end

        idle();
        repeat (3) step();
        check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        check("req_q_drained", 32'(req_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_pvci_bridge_mc.md
# apb_pvci_bridge_mc

Parametrised APB slave that bridges 32-bit APB accesses onto NUM_CH independent PVCI register ports, one per peripheral instance (e.g. several CAN controllers behind one APB window). It decodes a channel and a register index from the APB address and runs a request/acknowledge handshake to the selected channel. It inserts APB wait states until that channel acknowledges, and reports decode faults and stalls on pslverr.

## Interface
Parameters:
- NUM_CH, 2: number of PVCI channels, 1..8
- PVCI_AW, 8: PVCI register address width
- PVCI_DW, 8: PVCI data width, 8/16/32
- BASE_ADDRESS, 32'h1A108000: APB window base
- CH_STRIDE_LOG2, 12: log2 of the byte stride between channels
- TIMEOUT, 63: maximum acknowledge wait in cycles, 1..255

Ports:
- pclk  in  1  clock; all logic on the rising edge
- preset  in  1  synchronous, active-high reset
- paddr  in  32  APB address
- pwrite  in  1  1 = write
- pwdata  in  32  write data; only bits [PVCI_DW-1:0] are used
- psel  in  1  slave select
- penable  in  1  access phase
- prdata  out  32  read data, zero-extended
- pready  out  1  transfer complete
- pslverr  out  1  error; valid only while pready=1
- pvci_valid  out  NUM_CH  one-hot request
- pvci_rd  out  1  1 = read
- pvci_addr  out  PVCI_AW  register index
- pvci_wd  out  PVCI_DW  write data
- pvci_ack  in  NUM_CH  per-channel acknowledge
- pvci_rdata  in  NUM_CH*PVCI_DW  per-channel read data; channel c occupies [c*PVCI_DW +: PVCI_DW]

## Operation
- Decode:
  - off = paddr - BASE_ADDRESS
  - ch = off[CH_STRIDE_LOG2 +: clog2(NUM_CH)], with clog2 floored at 1
  - reg = off[2 +: PVCI_AW]; registers are word-spaced
- Decode error on any of:
  - paddr < BASE_ADDRESS
  - off >= NUM_CH << CH_STRIDE_LOG2
  - off[1:0] != 0
  - off bits between 2+PVCI_AW and CH_STRIDE_LOG2-1 nonzero
- FSM states: IDLE, REQ, DONE, ERR.
  - IDLE: on psel & !penable (setup phase), latch ch, reg, pwrite and pwdata[PVCI_DW-1:0]. Go to ERR on a decode error, otherwise to REQ.
  - REQ: drive pvci_valid[ch]=1 with pvci_rd=!pwrite, pvci_addr=reg and pvci_wd held stable. When pvci_ack[ch]=1, latch pvci_rdata slice into prdata (reads only) and go to DONE. Acks on other channels are ignored.
  - DONE: pready=1, pslverr=0, then go to IDLE.
  - ERR: pready=1, pslverr=1, prdata=0, no PVCI activity, then go to IDLE.
- pready is low in IDLE and REQ.
- A write leaves prdata at its previous value, and prdata is defined only while pready=1.
- pvci_valid is all-zero outside REQ.
- If psel drops mid-transfer (a protocol violation), the PVCI transaction still completes and the DONE/ERR pulse is issued anyway. Nothing is aborted.
- Reset values: state IDLE, pvci_valid=0, pvci_rd=0, pvci_addr=0, pvci_wd=0, prdata=0, pready=0, pslverr=0, timeout counter=0.
- Reset asserted mid-transfer: at the next edge the FSM is in IDLE with pvci_valid=0. The APB transfer is abandoned.

## Timing
- T0 = setup cycle (psel=1, penable=0).
- The FSM enters REQ at T0+1, with pvci_valid asserted in that cycle.
- An ack sampled at T0+1 gives DONE and pready=1 at T0+2, i.e. one APB wait state minimum.
- Each further cycle without ack adds one wait state.
- A decode error gives ERR at T0+1: pready and pslverr high in the first access cycle, zero wait states.
- Back-to-back transfers: the FSM returns to IDLE in the cycle after DONE/ERR, so a new setup phase is accepted there.
- All outputs are registered or decoded from state only; there is no combinational path from APB inputs to outputs.

## Configuration
- APB_PVCI_TIMEOUT_EN defined:
  - an 8-bit counter clears on REQ entry and increments each REQ cycle without ack
  - when it reaches TIMEOUT with no ack, pvci_valid drops and the FSM goes to ERR, giving pslverr=1 and prdata=0
  - if ack and expiry occur in the same cycle, ack wins and the FSM goes to DONE
- Undefined: no counter; REQ waits indefinitely for ack.

## Structure
- Package apb_pvci_pkg holds:
  - the state enum (IDLE, REQ, DONE, ERR)
  - the channel-index width function (clog2 floored at 1)
  - the counter width constant CNT_W=8
- Sub-module apb_pvci_decode: combinational decoder, paddr to {ch, reg, err}. Keeps the FSM module free of address arithmetic.

## Test plan
- Read ch1 reg 3 (paddr=BASE+0x100C, defaults), ack after 2 cycles, pvci_rdata slice 0xA5 -> pvci_valid=2'b10, pvci_addr=3, pvci_rd=1; pready after 3 wait states; prdata=0x000000A5; pslverr=0.
- Write pwdata=0xDEADBE5A to ch0 reg 0, immediate ack -> pvci_wd=0x5A, pvci_rd=0; one wait state; pslverr=0.
- paddr=BASE+0x2000 and paddr=BASE+0x0002 -> ERR in the first access cycle, pslverr=1, pvci_valid stays 0.
- APB_PVCI_TIMEOUT_EN with TIMEOUT=4, no ack -> pvci_valid high for exactly 4 cycles, then pready=1 and pslverr=1. A second run with ack in the 4th cycle -> DONE, pslverr=0.
- preset asserted in the 2nd REQ cycle -> next cycle shows pvci_valid=0, pready=0, state IDLE; the following transfer completes normally.
- Back-to-back read ch0 then write ch1 with ack held high -> each transfer completes with one wait state; no valid overlaps between channels.
